// File: rtl/vr_tx_merge_eng.sv
// rtl/vr_tx_merge_eng.sv - VR engine transmit merger: round-robin grant, beehive header insertion
// udp_info layout (INFO_W=112): {src_ip[111:80], dst_ip[79:48], src_port[47:32], dst_port[31:16], data_length[15:0]}
module vr_tx_merge_eng #(
  parameter int NOC_DATA_W     = 512,
  parameter int NOC_PADBYTES   = NOC_DATA_W / 8,
  parameter int NOC_PADBYTES_W = $clog2(NOC_PADBYTES),
  parameter int NUM_SRCS       = 4,
  parameter int HDR_BYTES      = 16,
  parameter int INFO_W         = 112
) (
  input  logic                                clk_i,
  input  logic                                rst_n_i,
  input  logic [NUM_SRCS-1:0]                 src_merge_meta_val_i,
  input  logic [NUM_SRCS*INFO_W-1:0]          src_merge_meta_info_i,
  input  logic [NUM_SRCS*8*HDR_BYTES-1:0]     src_merge_hdr_i,
  output logic [NUM_SRCS-1:0]                 merge_src_meta_rdy_o,
  input  logic [NUM_SRCS-1:0]                 src_merge_data_val_i,
  input  logic [NUM_SRCS*NOC_DATA_W-1:0]      src_merge_data_i,
  input  logic [NUM_SRCS-1:0]                 src_merge_data_last_i,
  input  logic [NUM_SRCS*NOC_PADBYTES_W-1:0]  src_merge_data_padbytes_i,
  output logic [NUM_SRCS-1:0]                 merge_src_data_rdy_o,
  output logic                                merge_udp_meta_val_o,
  output logic [INFO_W-1:0]                   merge_udp_meta_info_o,
  input  logic                                udp_merge_meta_rdy_i,
  output logic                                merge_udp_data_val_o,
  output logic [NOC_DATA_W-1:0]               merge_udp_data_o,
  output logic                                merge_udp_data_last_o,
  output logic [NOC_PADBYTES_W-1:0]           merge_udp_data_padbytes_o,
  input  logic                                udp_merge_data_rdy_i
);

  localparam int HDR_W = 8 * HDR_BYTES;
  localparam int PTR_W = (NUM_SRCS > 1) ? $clog2(NUM_SRCS) : 1;

  localparam logic [2:0] ST_ARB      = 3'd0;
  localparam logic [2:0] ST_META     = 3'd1;
  localparam logic [2:0] ST_HDR_ONLY = 3'd2;
  localparam logic [2:0] ST_DATA     = 3'd3;
  localparam logic [2:0] ST_TAIL     = 3'd4;

  logic [2:0]                state_q, state_d;
  logic [PTR_W-1:0]          rr_ptr_q, rr_ptr_d;
  logic [PTR_W-1:0]          grant_q, grant_d;
  logic [INFO_W-1:0]         info_q, info_d;
  logic [HDR_W-1:0]          hdr_q, hdr_d;
  logic [HDR_W-1:0]          carry_q, carry_d;
  logic [NOC_PADBYTES_W-1:0] pad_q, pad_d;
  logic                      first_q, first_d;

  logic [INFO_W-1:0]         info_arr [NUM_SRCS];
  logic [HDR_W-1:0]          hdr_arr  [NUM_SRCS];
  logic [NOC_DATA_W-1:0]     data_arr [NUM_SRCS];
  logic [NOC_PADBYTES_W-1:0] pad_arr  [NUM_SRCS];

  for (genvar gi = 0; gi < NUM_SRCS; gi++) begin : g_unpack
    assign info_arr[gi] = src_merge_meta_info_i[gi*INFO_W +: INFO_W];
    assign hdr_arr[gi]  = src_merge_hdr_i[gi*HDR_W +: HDR_W];
    assign data_arr[gi] = src_merge_data_i[gi*NOC_DATA_W +: NOC_DATA_W];
    assign pad_arr[gi]  = src_merge_data_padbytes_i[gi*NOC_PADBYTES_W +: NOC_PADBYTES_W];
  end

  logic                      g_val, g_last, g_fits;
  logic [NOC_DATA_W-1:0]     g_data;
  logic [NOC_PADBYTES_W-1:0] g_pad;

  assign g_val  = src_merge_data_val_i[grant_q];
  assign g_last = src_merge_data_last_i[grant_q];
  assign g_data = data_arr[grant_q];
  assign g_pad  = pad_arr[grant_q];
  // The shifted-out header bytes fit in the last word iff its unused tail is at least HDR_BYTES.
  assign g_fits = (g_pad >= NOC_PADBYTES_W'(HDR_BYTES));

  logic             pick_found;
  logic [PTR_W-1:0] pick_idx;
  logic [PTR_W-1:0] cand;

  // Round-robin search for the first pending meta starting at rr_ptr.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int k = 0; k < NUM_SRCS; k++) begin
      cand = PTR_W'((int'(rr_ptr_q) + k) % NUM_SRCS);
      if (!pick_found && src_merge_meta_val_i[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // Message FSM: grant, emit meta, then header-shifted payload words.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    info_d   = info_q;
    hdr_d    = hdr_q;
    carry_d  = carry_q;
    pad_d    = pad_q;
    first_d  = first_q;

    merge_src_meta_rdy_o      = '0;
    merge_src_data_rdy_o      = '0;
    merge_udp_meta_val_o      = 1'b0;
    merge_udp_meta_info_o     = {info_q[INFO_W-1:16], info_q[15:0] + 16'(HDR_BYTES)};
    merge_udp_data_val_o      = 1'b0;
    merge_udp_data_o          = {hdr_q, g_data[NOC_DATA_W-1:HDR_W]};
    merge_udp_data_last_o     = 1'b0;
    merge_udp_data_padbytes_o = '0;

    case (state_q)
      ST_ARB: begin
        if (pick_found) begin
          merge_src_meta_rdy_o[pick_idx] = 1'b1;
          grant_d  = pick_idx;
          info_d   = info_arr[pick_idx];
          hdr_d    = hdr_arr[pick_idx];
          rr_ptr_d = (pick_idx == PTR_W'(NUM_SRCS - 1)) ? '0 : pick_idx + 1'b1;
          state_d  = ST_META;
        end
      end
      ST_META: begin
        merge_udp_meta_val_o = 1'b1;
        if (udp_merge_meta_rdy_i) begin
          first_d = 1'b1;
          state_d = (info_q[15:0] != 16'd0) ? ST_DATA : ST_HDR_ONLY;
        end
      end
      ST_HDR_ONLY: begin
        merge_udp_data_val_o      = 1'b1;
        merge_udp_data_o          = {hdr_q, {(NOC_DATA_W-HDR_W){1'b0}}};
        merge_udp_data_last_o     = 1'b1;
        merge_udp_data_padbytes_o = NOC_PADBYTES_W'(NOC_PADBYTES - HDR_BYTES);
        if (udp_merge_data_rdy_i) state_d = ST_ARB;
      end
      ST_DATA: begin
        merge_src_data_rdy_o[grant_q] = udp_merge_data_rdy_i;
        merge_udp_data_val_o          = g_val;
        merge_udp_data_o              = {(first_q ? hdr_q : carry_q), g_data[NOC_DATA_W-1:HDR_W]};
        if (g_last && g_fits) begin
          merge_udp_data_last_o     = 1'b1;
          merge_udp_data_padbytes_o = g_pad - NOC_PADBYTES_W'(HDR_BYTES);
        end
        if (g_val && udp_merge_data_rdy_i) begin
          carry_d = g_data[HDR_W-1:0];
          first_d = 1'b0;
          if (g_last) begin
            pad_d   = g_pad;
            state_d = g_fits ? ST_ARB : ST_TAIL;
          end
        end
      end
      ST_TAIL: begin
        merge_udp_data_val_o      = 1'b1;
        merge_udp_data_o          = {carry_q, {(NOC_DATA_W-HDR_W){1'b0}}};
        merge_udp_data_last_o     = 1'b1;
        merge_udp_data_padbytes_o = NOC_PADBYTES_W'(NOC_PADBYTES - HDR_BYTES) + pad_q;
        if (udp_merge_data_rdy_i) state_d = ST_ARB;
      end
      default: begin
        state_d                   = 'x;
        merge_udp_meta_val_o      = 1'bx;
        merge_udp_data_val_o      = 1'bx;
        merge_udp_data_o          = 'x;
        merge_udp_data_last_o     = 1'bx;
        merge_udp_data_padbytes_o = 'x;
      end
    endcase

    if (!rst_n_i) begin
      merge_src_meta_rdy_o = '0;
      merge_src_data_rdy_o = '0;
      merge_udp_meta_val_o = 1'b0;
      merge_udp_data_val_o = 1'b0;
    end
  end

  // Control state with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q  <= ST_ARB;
      rr_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  // Per-message datapath registers; only meaningful after a grant.
  always_ff @(posedge clk_i) begin
    grant_q <= grant_d;
    info_q  <= info_d;
    hdr_q   <= hdr_d;
    carry_q <= carry_d;
    pad_q   <= pad_d;
    first_q <= first_d;
  end

endmodule

// File: tb/tb_vr_tx_merge_eng.sv
// tb/tb_vr_tx_merge_eng.sv - self-checking bench for vr_tx_merge_eng
module tb_vr_tx_merge_eng;

  localparam int W   = 512;
  localparam int N   = 4;
  localparam int HB  = 16;
  localparam int HW  = 128;
  localparam int IW  = 112;
  localparam int PBW = 6;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    s_meta_val;
  logic [N*IW-1:0] s_meta_info;
  logic [N*HW-1:0] s_hdr;
  logic [N-1:0]    m_meta_rdy;
  logic [N-1:0]    s_data_val;
  logic [N*W-1:0]  s_data;
  logic [N-1:0]    s_last;
  logic [N*PBW-1:0] s_pad;
  logic [N-1:0]    m_data_rdy;
  logic            o_meta_val;
  logic [IW-1:0]   o_info;
  logic            u_meta_rdy;
  logic            o_data_val;
  logic [W-1:0]    o_data;
  logic            o_last;
  logic [PBW-1:0]  o_pad;
  logic            u_data_rdy;

  vr_tx_merge_eng dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .src_merge_meta_val_i(s_meta_val), .src_merge_meta_info_i(s_meta_info),
    .src_merge_hdr_i(s_hdr), .merge_src_meta_rdy_o(m_meta_rdy),
    .src_merge_data_val_i(s_data_val), .src_merge_data_i(s_data),
    .src_merge_data_last_i(s_last), .src_merge_data_padbytes_i(s_pad),
    .merge_src_data_rdy_o(m_data_rdy),
    .merge_udp_meta_val_o(o_meta_val), .merge_udp_meta_info_o(o_info),
    .udp_merge_meta_rdy_i(u_meta_rdy),
    .merge_udp_data_val_o(o_data_val), .merge_udp_data_o(o_data),
    .merge_udp_data_last_o(o_last), .merge_udp_data_padbytes_o(o_pad),
    .udp_merge_data_rdy_i(u_data_rdy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // source model
  bit meta_pend [N];
  int words_left [N], word_idx [N], len_m [N], msg_m [N], pad_in_m [N];
  // output monitor
  bit in_msg;
  int cur_s, cur_m, cur_len, ow, nout;
  int msgs_loaded, msgs_done, grants_total;
  int last_meta_len, last_words, last_pad;
  int grant_log [$];
  bit stall_mode;
  bit prev_dstall, prev_mstall;
  logic [W-1:0] pd; logic pl; logic [PBW-1:0] pp; logic [IW-1:0] pi;
  logic [3:0] snap_vals;

  typedef struct {
    int src; int len; int exp_meta_len; int exp_words; int exp_last_pad; bit stall;
  } vec_t;
  localparam int NV = 10;
  vec_t vecs [NV];

  task automatic chk(input bit ok, input string name, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic logic [7:0] hdr_byte(int s, int m, int b);
    return 8'(s*50 + m*13 + b + 128);
  endfunction
  function automatic logic [7:0] pay_byte(int s, int m, int k, int b);
    return 8'(s*37 + m*11 + k*64 + b*3 + 5);
  endfunction
  function automatic logic [HW-1:0] hdr_word(int s, int m);
    logic [HW-1:0] w;
    for (int b = 0; b < HB; b++) w[HW-1-8*b -: 8] = hdr_byte(s, m, b);
    return w;
  endfunction
  function automatic logic [W-1:0] pay_word(int s, int m, int k);
    logic [W-1:0] w;
    for (int b = 0; b < W/8; b++) w[W-1-8*b -: 8] = pay_byte(s, m, k, b);
    return w;
  endfunction
  function automatic logic [7:0] exp_byte(int s, int m, int i);
    if (i < HB) return hdr_byte(s, m, i);
    return pay_byte(s, m, (i-HB)/64, (i-HB)%64);
  endfunction
  function automatic logic [IW-1:0] exp_info(int s, int m, int len);
    return {32'hC0A80000 + 32'(s), 32'h0A000001, 16'(m), 16'(s), 16'(len)};
  endfunction

  task automatic drive_srcs();
    for (int s = 0; s < N; s++) begin
      s_meta_val[s] = meta_pend[s];
      s_meta_info[s*IW +: IW] = exp_info(s, msg_m[s], len_m[s]);
      s_hdr[s*HW +: HW] = hdr_word(s, msg_m[s]);
      s_data_val[s] = !meta_pend[s] && (words_left[s] > 0);
      s_data[s*W +: W] = pay_word(s, msg_m[s], word_idx[s]);
      s_last[s] = (words_left[s] == 1);
      s_pad[s*PBW +: PBW] = (words_left[s] == 1) ? PBW'(pad_in_m[s]) : '0;
    end
  endtask

  task automatic clear_srcs();
    for (int s = 0; s < N; s++) begin
      meta_pend[s] = 1'b0; words_left[s] = 0; word_idx[s] = 0;
    end
    drive_srcs();
  endtask

  task automatic load_msg(input int s, input int len);
    msg_m[s]++;
    len_m[s] = len;
    words_left[s] = (len + 63) / 64;
    word_idx[s] = 0;
    pad_in_m[s] = words_left[s]*64 - len;
    meta_pend[s] = 1'b1;
    msgs_loaded++;
    drive_srcs();
  endtask

  // one clock: sample/check at negedge, advance source model after posedge
  task automatic step();
    logic [N-1:0] mhs, dhs, allowed, pend;
    bit ok; int bad; logic [7:0] ab, eb; int ep; bit lastx; int s;
    @(negedge clk);
    mhs = s_meta_val & m_meta_rdy;
    dhs = s_data_val & m_data_rdy;
    snap_vals = {o_meta_val, o_data_val, |m_meta_rdy, |m_data_rdy};
    if (prev_dstall)
      chk(o_data_val && o_data == pd && o_last == pl && o_pad == pp, "data_hold", longint'(o_last), longint'(pl));
    if (prev_mstall)
      chk(o_meta_val && o_info == pi, "meta_hold", longint'(o_info[15:0]), longint'(pi[15:0]));
    for (int k = 0; k < N; k++) begin
      allowed[k] = in_msg && (k == cur_s) && (words_left[k] > 0);
      pend[k] = meta_pend[k];
    end
    chk((m_data_rdy & ~allowed) == '0, "src_data_rdy", longint'(m_data_rdy), longint'(allowed));
    if (m_meta_rdy != '0)
      chk(((m_meta_rdy & ~pend) == '0) && $countones(m_meta_rdy) == 1 && grants_total == msgs_done,
          "meta_grant_lock", longint'(m_meta_rdy), longint'(pend));
    if (o_meta_val && u_meta_rdy) begin
      s = int'(o_info[31:16]);
      chk(!in_msg && s < N, "meta_out_ok", longint'(s), longint'(cur_s));
      if (s < N) begin
        chk(o_info == exp_info(s, msg_m[s], len_m[s] + HB), "meta_info",
            longint'(o_info[15:0]), longint'(len_m[s] + HB));
        in_msg = 1'b1; cur_s = s; cur_m = msg_m[s]; cur_len = len_m[s];
        ow = 0; nout = (HB + cur_len + 63) / 64;
        last_meta_len = int'(o_info[15:0]);
      end
    end
    if (o_data_val && u_data_rdy) begin
      if (!in_msg) chk(1'b0, "stray_word", 1, 0);
      else begin
        lastx = (ow == nout - 1);
        ep = lastx ? (nout*64 - (HB + cur_len)) : 0;
        ok = 1'b1; bad = 0; ab = '0; eb = '0;
        for (int b = 0; b < 64 - ep; b++) begin
          if (ok && o_data[W-1-8*b -: 8] != exp_byte(cur_s, cur_m, ow*64 + b)) begin
            ok = 1'b0; bad = b; ab = o_data[W-1-8*b -: 8]; eb = exp_byte(cur_s, cur_m, ow*64 + b);
          end
        end
        chk(ok, $sformatf("word_bytes w%0d b%0d", ow, bad), longint'(ab), longint'(eb));
        chk(o_last == lastx, $sformatf("word_last w%0d", ow), longint'(o_last), longint'(lastx));
        if (lastx) chk(o_pad == PBW'(ep), "word_pad", longint'(o_pad), longint'(ep));
        ow++;
        if (lastx) begin
          in_msg = 1'b0; msgs_done++; last_words = ow; last_pad = int'(o_pad);
        end
      end
    end
    prev_dstall = rst_n && o_data_val && !u_data_rdy;
    prev_mstall = rst_n && o_meta_val && !u_meta_rdy;
    pd = o_data; pl = o_last; pp = o_pad; pi = o_info;
    @(posedge clk); #1;
    for (int k = 0; k < N; k++) begin
      if (mhs[k]) begin meta_pend[k] = 1'b0; grant_log.push_back(k); grants_total++; end
      if (dhs[k]) begin word_idx[k]++; words_left[k]--; end
    end
    u_meta_rdy = stall_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    u_data_rdy = stall_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
    drive_srcs();
  endtask

  task automatic run_all(input int budget, input string name);
    int n = 0;
    while (msgs_done != msgs_loaded && n < budget) begin step(); n++; end
    chk(msgs_done == msgs_loaded, {"timeout_", name}, msgs_done, msgs_loaded);
  endtask

  task automatic do_reset(input int cycles);
    rst_n = 1'b0;
    clear_srcs();
    in_msg = 1'b0; msgs_done = msgs_loaded; grants_total = msgs_done;
    prev_dstall = 1'b0; prev_mstall = 1'b0;
    for (int i = 0; i < cycles; i++) step();
    chk(snap_vals == 4'b0, "vals_in_reset", longint'(snap_vals), 0);
    rst_n = 1'b1;
    step();
    chk(snap_vals == 4'b0, "vals_after_reset", longint'(snap_vals), 0);
  endtask

  initial begin
    int g0, n;
    rst_n = 1'b0; stall_mode = 1'b0; u_meta_rdy = 1'b0; u_data_rdy = 1'b0;
    in_msg = 1'b0; msgs_loaded = 0; msgs_done = 0; grants_total = 0;
    cur_s = 0; cur_m = 0; cur_len = 0; ow = 0; nout = 0;
    last_meta_len = 0; last_words = 0; last_pad = 0;
    prev_dstall = 1'b0; prev_mstall = 1'b0;
    for (int s = 0; s < N; s++) begin msg_m[s] = 0; len_m[s] = 0; pad_in_m[s] = 0; end
    clear_srcs();

    vecs[0] = '{1,  40,  56, 1,  8, 1'b0};
    vecs[1] = '{0,  60,  76, 2, 52, 1'b0};
    vecs[2] = '{3,   0,  16, 1, 48, 1'b0};
    vecs[3] = '{2,  64,  80, 2, 48, 1'b0};
    vecs[4] = '{0,  48,  64, 1,  0, 1'b0};
    vecs[5] = '{1, 130, 146, 3, 46, 1'b0};
    vecs[6] = '{2,   1,  17, 1, 47, 1'b0};
    vecs[7] = '{3, 112, 128, 2,  0, 1'b0};
    vecs[8] = '{2, 300, 316, 5,  4, 1'b1};
    vecs[9] = '{0, 310, 326, 6, 58, 1'b1};

    do_reset(3);

    // simultaneous meta on 0, 2, 3 with rr_ptr at 0
    g0 = grant_log.size();
    load_msg(0, 60); load_msg(2, 20); load_msg(3, 100);
    run_all(200, "arb3");
    chk(grant_log.size() == g0 + 3, "arb3_count", grant_log.size() - g0, 3);
    if (grant_log.size() == g0 + 3) begin
      chk(grant_log[g0] == 0, "arb3_first", grant_log[g0], 0);
      chk(grant_log[g0+1] == 2, "arb3_second", grant_log[g0+1], 2);
      chk(grant_log[g0+2] == 3, "arb3_third", grant_log[g0+2], 3);
    end
    // rr_ptr wrapped to 0: with 0 and 1 pending, 0 wins
    g0 = grant_log.size();
    load_msg(1, 10); load_msg(0, 10);
    run_all(100, "rr_wrap");
    chk(grant_log.size() == g0 + 2 && grant_log[g0] == 0 && grant_log[g0+1] == 1, "rr_wrap_order",
        (grant_log.size() > g0) ? grant_log[g0] : -1, 0);

    for (int i = 0; i < NV; i++) begin
      stall_mode = vecs[i].stall;
      g0 = grant_log.size();
      load_msg(vecs[i].src, vecs[i].len);
      run_all(400, $sformatf("vec%0d", i));
      chk(last_meta_len == vecs[i].exp_meta_len, $sformatf("vec%0d_meta_len", i), last_meta_len, vecs[i].exp_meta_len);
      chk(last_words == vecs[i].exp_words, $sformatf("vec%0d_words", i), last_words, vecs[i].exp_words);
      chk(last_pad == vecs[i].exp_last_pad, $sformatf("vec%0d_pad", i), last_pad, vecs[i].exp_last_pad);
      chk(grant_log.size() == g0 + 1 && grant_log[g0] == vecs[i].src, $sformatf("vec%0d_grant", i),
          (grant_log.size() > g0) ? grant_log[g0] : -1, vecs[i].src);
    end
    stall_mode = 1'b0;

    // reset in the middle of a DATA phase
    load_msg(1, 200);
    n = 0;
    while (!(in_msg && ow >= 1) && n < 50) begin step(); n++; end
    chk(in_msg && ow >= 1, "reach_mid_data", ow, 1);
    do_reset(1);
    load_msg(1, 40);
    run_all(100, "post_reset");
    chk(last_meta_len == 56, "post_reset_meta_len", last_meta_len, 56);
    chk(last_words == 1, "post_reset_words", last_words, 1);
    chk(last_pad == 8, "post_reset_pad", last_pad, 8);

    for (int i = 0; i < 3; i++) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
